// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer controller.
// Contents: write-FSM state type, a constant-friendly clog2, the RGB444
// pixel width and the default background colour.
package fb_pkg;

  localparam int RGB444_W = 12;
  localparam logic [RGB444_W-1:0] BG_DEFAULT = 12'h000;

  typedef enum logic {
    W_FILL,
    W_DONE
  } wr_state_t;

  // Number of bits needed to index 'value' items (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write FIFO for pending rx pixels.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   push, push_data   enqueue request and data (ignored when full unless a
//                     pop happens in the same cycle)
//   pop               dequeue request (ignored when empty)
//   flush             empties the FIFO on the next edge
//   pop_data          head of the FIFO (show-ahead)
//   full, empty       occupancy flags
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int PW = clog2(DEPTH);

  logic [DW-1:0] store [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          do_pop;
  logic          do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full is accepted.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = store[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/frame_buf_ctrl.sv
// Multi-bank frame-buffer controller between the rx pixel stream and the
// VGA timing generator, sharing one single-port SPRAM.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   rx_valid, rx_data     incoming pixel strobe and value (raster order)
//   wr_abort              discard the partially received frame
//   x_addr, y_addr        current VGA column/row
//   frame_start           pulse at vertical-blank start; bank swap point
//   pix_out               pixel for the coordinates sampled two clocks
//                         before the edge that updates it
//   mem_addr/wdata/we     SPRAM command (registered)
//   mem_rdata             SPRAM read data, one clock after mem_addr
//   front_bank            bank currently displayed
//   frame_ready           back bank full, waiting for frame_start
//   overflow              sticky: an rx pixel was dropped on a full FIFO
module frame_buf_ctrl
  import fb_pkg::*;
#(
  parameter int               PIX_W      = RGB444_W,
  parameter int               W          = 160,
  parameter int               H          = 120,
  parameter int               NBANK      = 2,
  parameter int               SCALE_LG2  = 0,
  parameter int               STARTROW   = 0,
  parameter int               STARTCOL   = 0,
  parameter int               FIFO_DEPTH = 16,
  parameter logic [PIX_W-1:0] BG_COLOR   = BG_DEFAULT,
  localparam int              AW         = clog2(W * H) + clog2(NBANK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [PIX_W-1:0] rx_data,
  input  logic             wr_abort,
  input  logic [11:0]      x_addr,
  input  logic [11:0]      y_addr,
  input  logic             frame_start,
  output logic [PIX_W-1:0] pix_out,
  output logic [AW-1:0]    mem_addr,
  output logic [PIX_W-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic [1:0]       front_bank,
  output logic             frame_ready,
  output logic             overflow
);

  localparam logic [AW-1:0] NPIX_A = AW'(W * H);
  localparam logic [AW-1:0] W_A    = AW'(W);
  localparam logic [11:0]   WIN_W  = 12'(W << SCALE_LG2);
  localparam logic [11:0]   WIN_H  = 12'(H << SCALE_LG2);

  wr_state_t        state;
  logic [1:0]       back_bank;
  logic [1:0]       back_bank_next;
  logic [AW-1:0]    pix_cnt;
  logic             win_s1;
  logic             win_s2;

  logic [12:0]      x_rel;
  logic [12:0]      y_rel;
  logic             in_win;
  logic [AW-1:0]    raddr;
  logic [AW-1:0]    waddr;
  logic             pop_en;

  logic [PIX_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  // Stage S0: window test and read address. The extra MSB of the
  // subtraction is a borrow flag, so coordinates left of/above the window
  // are rejected without any wrap-around reaching the address math.
  always_comb begin
    x_rel  = {1'b0, x_addr} - 13'(STARTCOL);
    y_rel  = {1'b0, y_addr} - 13'(STARTROW);
    in_win = !x_rel[12] && (x_rel[11:0] < WIN_W) &&
             !y_rel[12] && (y_rel[11:0] < WIN_H);
    raddr  = AW'(front_bank) * NPIX_A
           + AW'(y_rel[11:0] >> SCALE_LG2) * W_A
           + AW'(x_rel[11:0] >> SCALE_LG2);
    waddr  = AW'(back_bank) * NPIX_A + pix_cnt;
  end

  // Reads own the port whenever the beam is inside the window; writes only
  // drain while filling, so a completed back bank is never overwritten.
  assign pop_en = !in_win && !fifo_empty && (state == W_FILL) && !wr_abort;

  // Next back bank: successor modulo NBANK. The successor of the old back
  // bank can never equal it (NBANK >= 2), so the new front is skipped.
  always_comb begin
    back_bank_next = (back_bank == 2'(NBANK - 1)) ? 2'd0 : back_bank + 2'd1;
  end

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (PIX_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_valid && !wr_abort),
    .push_data (rx_data),
    .pop       (pop_en),
    .flush     (wr_abort),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= W_FILL;
      back_bank   <= 2'd1;
      front_bank  <= 2'd0;
      pix_cnt     <= '0;
      frame_ready <= 1'b0;
      overflow    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      win_s1      <= 1'b0;
      win_s2      <= 1'b0;
      pix_out     <= BG_COLOR;
    end else begin
      // S1 holds the address at the RAM; S2 captures the returned pixel.
      win_s1  <= in_win;
      win_s2  <= win_s1;
      pix_out <= win_s2 ? mem_rdata : BG_COLOR;

      if (in_win) begin
        mem_we   <= 1'b0;
        mem_addr <= raddr;
      end else if (pop_en) begin
        mem_we    <= 1'b1;
        mem_addr  <= waddr;
        mem_wdata <= fifo_dout;
      end else begin
        mem_we <= 1'b0;
      end

      if (rx_valid && fifo_full && !pop_en && !wr_abort) overflow <= 1'b1;

      if (wr_abort) begin
        pix_cnt     <= '0;
        state       <= W_FILL;
        frame_ready <= 1'b0;
      end else begin
        case (state)
          W_FILL: begin
            if (pop_en) begin
              if (pix_cnt == NPIX_A - 1'b1) begin
                state       <= W_DONE;
                frame_ready <= 1'b1;
              end else begin
                pix_cnt <= pix_cnt + 1'b1;
              end
            end
          end
          W_DONE: begin
            if (frame_start) begin
              front_bank  <= back_bank;
              back_bank   <= back_bank_next;
              pix_cnt     <= '0;
              frame_ready <= 1'b0;
              state       <= W_FILL;
            end
          end
          default: state <= W_FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Bench for frame_buf_ctrl: a 3x2, two-bank unscaled instance (dut) driven
// through fill, swap, contention, abort and reset scenarios, plus a 2x
// upscaled instance (dut_sc) used for the scaled address mapping.
module tb_frame_buf_ctrl;

  localparam int AW = 4;
  localparam int NP = 6;
  localparam logic [11:0] BG = 12'h000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [11:0]   rx_data = '0;
  logic          wr_abort = 1'b0;
  logic [11:0]   x_addr = 12'd100;
  logic [11:0]   y_addr = 12'd100;
  logic          frame_start = 1'b0;
  logic [11:0]   pix_out;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_wdata;
  logic          mem_we;
  logic [11:0]   mem_rdata;
  logic [1:0]    front_bank;
  logic          frame_ready;
  logic          overflow;

  logic [11:0]   x_sc = 12'd100;
  logic [11:0]   y_sc = 12'd100;
  logic [11:0]   pix_out_sc;
  logic [AW-1:0] mem_addr_sc;
  logic [11:0]   mem_wdata_sc;
  logic          mem_we_sc;
  logic [11:0]   mem_rdata_sc;
  logic [1:0]    front_bank_sc;
  logic          frame_ready_sc;
  logic          overflow_sc;

  frame_buf_ctrl #(
    .PIX_W(12), .W(3), .H(2), .NBANK(2), .SCALE_LG2(0),
    .STARTROW(0), .STARTCOL(0), .FIFO_DEPTH(16), .BG_COLOR(12'h000)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_abort(wr_abort), .x_addr(x_addr), .y_addr(y_addr),
    .frame_start(frame_start), .pix_out(pix_out), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .front_bank(front_bank), .frame_ready(frame_ready), .overflow(overflow)
  );

  frame_buf_ctrl #(
    .PIX_W(12), .W(3), .H(2), .NBANK(2), .SCALE_LG2(1),
    .STARTROW(0), .STARTCOL(0), .FIFO_DEPTH(16), .BG_COLOR(12'h000)
  ) dut_sc (
    .clk(clk), .rst(rst), .rx_valid(1'b0), .rx_data(12'h000),
    .wr_abort(1'b0), .x_addr(x_sc), .y_addr(y_sc),
    .frame_start(1'b0), .pix_out(pix_out_sc), .mem_addr(mem_addr_sc),
    .mem_wdata(mem_wdata_sc), .mem_we(mem_we_sc), .mem_rdata(mem_rdata_sc),
    .front_bank(front_bank_sc), .frame_ready(frame_ready_sc), .overflow(overflow_sc)
  );

  // SPRAM models and write log
  logic [11:0] ram [16];
  logic [11:0] ram_sc [16];
  logic [15:0] wr_log [$];

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_log.push_back({mem_addr, mem_wdata});
    end
  end

  always @(posedge clk) mem_rdata_sc <= ram_sc[mem_addr_sc];

  // Behavioural reference model
  int          m_front, m_back, m_cnt;
  bit          m_done, m_ovf;
  logic [11:0] m_q [$];
  logic [11:0] m_mem [16];
  logic [15:0] exp_wr [$];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_front = 0; m_back = 1; m_cnt = 0; m_done = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic m_push(input logic [11:0] d);
    if (m_q.size() < 16) m_q.push_back(d);
    else m_ovf = 1;
  endtask

  // Everything queued drains into the back bank in raster order until full.
  task automatic m_drain();
    int a;
    logic [11:0] d;
    while (!m_done && m_q.size() > 0) begin
      a = m_back * NP + m_cnt;
      d = m_q.pop_front();
      m_mem[a] = d;
      exp_wr.push_back({4'(a), d});
      m_cnt++;
      if (m_cnt == NP) m_done = 1;
    end
  endtask

  task automatic m_swap();
    if (m_done) begin
      m_front = m_back;
      m_back = (m_back + 1) % 2;
      m_cnt = 0;
      m_done = 0;
    end
  endtask

  task automatic m_abort();
    m_cnt = 0; m_done = 0;
    m_q.delete();
  endtask

  function automatic logic [11:0] m_pix(input int x, input int y);
    if (x < 3 && y < 2) return m_mem[m_front * NP + y * 3 + x];
    return BG;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [11:0] d);
    rx_valid = 1'b1;
    rx_data = d;
    m_push(d);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_swap();
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_count"}, wr_log.size(), exp_wr.size());
    n = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
    for (int i = 0; i < n; i++) begin
      check(tag, wr_log[i], exp_wr[i]);
      $display("write %s: addr=%0d data=%03h expected addr=%0d data=%03h",
               tag, wr_log[i][15:12], wr_log[i][11:0], exp_wr[i][15:12], exp_wr[i][11:0]);
    end
    wr_log.delete();
    exp_wr.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_out"}, pix_out, BG);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 4'd0);
    check({tag, "_front"}, front_bank, 2'd0);
    check({tag, "_ready"}, frame_ready, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
  endtask

  // Random reads through the 3-stage pipeline: pix_out after the edge that
  // samples coordinates n+2 belongs to coordinates n.
  task automatic random_reads(input string tag, input int n);
    logic [11:0] q [$];
    int x, y;
    for (int i = 0; i < n + 2; i++) begin
      x = $urandom_range(0, 5);
      y = $urandom_range(0, 3);
      x_addr = 12'(x);
      y_addr = 12'(y);
      q.push_back(m_pix(x, y));
      tick();
      if (q.size() == 3) begin
        check(tag, pix_out, q[0]);
        $display("read %s: pix_out=%03h expected=%03h", tag, pix_out, q[0]);
        void'(q.pop_front());
      end
    end
    x_addr = 12'd100;
    y_addr = 12'd100;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = '0;
      ram_sc[i] = 12'($urandom);
      m_mem[i] = '0;
    end
    m_reset();

    // Reset state
    rst = 1'b1;
    wait_ticks(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // First frame: 001..006 into bank 1
    for (int i = 1; i <= 6; i++) send(12'(i));
    wait_ticks(6);
    m_drain();
    check_writes("fill");
    check("fill_ready", frame_ready, m_done);
    check("fill_front", front_bank, 2'(m_front));

    pulse_frame_start();
    check("swap_front", front_bank, 2'(m_front));
    check("swap_ready", frame_ready, 1'b0);

    // (2,1) reads the last pixel of the new front bank
    x_addr = 12'd2; y_addr = 12'd1;
    wait_ticks(3);
    check("read_2_1", pix_out, m_pix(2, 1));

    // Outside the window the port is free for a pending write
    x_addr = 12'd5; y_addr = 12'd0;
    send(12'($urandom));
    m_drain();
    tick();
    check("outside_we", mem_we, 1'b1);
    tick();
    check("outside_bg", pix_out, BG);
    tick();
    check_writes("outside");

    random_reads("rand_a", 10);

    // Contention: reads hold the port while 20 pixels arrive
    wr_abort = 1'b1; tick(); wr_abort = 1'b0; m_abort();
    x_addr = 12'd0; y_addr = 12'd0;
    for (int i = 1; i <= 20; i++) begin
      send(12'($urandom));
      check("cont_we", mem_we, 1'b0);
      check("cont_overflow", overflow, m_ovf);
    end
    x_addr = 12'd100; y_addr = 12'd100;
    wait_ticks(10);
    m_drain();
    check_writes("drain1");
    check("drain1_ready", frame_ready, m_done);
    pulse_frame_start();
    wait_ticks(10);
    m_drain();
    check_writes("drain2");
    check("drain2_front", front_bank, 2'(m_front));
    pulse_frame_start();
    wait_ticks(10);
    m_drain();
    check_writes("drain3");
    check("drain3_front", front_bank, 2'(m_front));
    check("drain3_overflow", overflow, m_ovf);

    // Reset with pixels still pending
    for (int i = 0; i < 3; i++) send(12'($urandom));
    wait_ticks(4);
    m_drain();
    check_writes("prereset");
    rst = 1'b1;
    wait_ticks(2);
    check_reset_outputs("midreset");
    rst = 1'b0;
    m_reset();
    tick();

    // Abort after 4 of 6 pixels; frame_start while filling does nothing
    for (int i = 0; i < 4; i++) send(12'($urandom));
    wait_ticks(4);
    m_drain();
    pulse_frame_start();
    check("fill_swap_ignored", front_bank, 2'(m_front));
    wr_abort = 1'b1; tick(); wr_abort = 1'b0; m_abort();
    for (int i = 0; i < 6; i++) send(12'($urandom));
    wait_ticks(6);
    m_drain();
    check_writes("abort");
    check("abort_ready", frame_ready, m_done);
    check("abort_front", front_bank, 2'(m_front));
    pulse_frame_start();
    check("abort_swap_front", front_bank, 2'(m_front));

    random_reads("rand_b", 12);

    // 2x upscale: (2,0) and (3,1) both map to address 1; (6,0) is outside
    x_sc = 12'd2; y_sc = 12'd0;
    tick();
    check("scale_addr_2_0", mem_addr_sc, 4'd1);
    x_sc = 12'd3; y_sc = 12'd1;
    tick();
    check("scale_addr_3_1", mem_addr_sc, 4'd1);
    x_sc = 12'd6; y_sc = 12'd0;
    tick();
    check("scale_pix_2_0", pix_out_sc, ram_sc[1]);
    x_sc = 12'd100; y_sc = 12'd100;
    tick();
    check("scale_pix_3_1", pix_out_sc, ram_sc[1]);
    tick();
    check("scale_pix_6_0", pix_out_sc, BG);
    check("scale_no_write", mem_we_sc, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
